uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data-memory bus beside `memory` and responds to processor loads and stores in its address window. Stores to the DATA register push bytes into a small TX FIFO. A serializer drains the FIFO onto a single 8N1 line, LSB first. A STATUS register lets firmware poll for space, busy state and overflow before it writes.

---
 rtl/uart_tx_mmio.sv | 90 +++++++++
 tb/tb_uart_tx_mmio.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO and a pollable STATUS register
module uart_tx_mmio #(
  parameter int          CLK_FREQ   = 12_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq_empty
);
  localparam int CPB = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, rp_q, used;
  logic [31:0]   rd_q;
  logic          tx_q, irq_q, ov_q;
  logic          hit, wr_data, rd_stat, full, empty, push, pop, bit_end, busy;
  logic [3:0]    occ;
  logic          unused_ok;
  assign hit       = address[31:3] == BASE_ADDR[31:3];
  assign wr_data   = hit && write_mem && !address[2];
  assign rd_stat   = hit && !write_mem && address[2];
  assign empty     = wp_q == rp_q;
  assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push      = wr_data && !full;
  assign bit_end   = cnt_q == CW'(CPB - 1);
  assign busy      = state_q != IDLE;
  assign pop       = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign used      = wp_q - rp_q;
  assign occ       = 32'(used) > 32'd15 ? 4'hf : 4'(used);
  assign unused_ok = ^{funct3, write_data[31:8], address[1:0]};
  assign read_data = rd_q;
  assign tx        = tx_q;
  assign irq_empty = irq_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      rd_q    <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
      ov_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wp_q[AW-1:0]] <= write_data[7:0];
        wp_q                <= wp_q + 1'b1;
      end
      if (pop) begin
        shift_q <= mem_q[rp_q[AW-1:0]];
        rp_q    <= rp_q + 1'b1;
      end
      ov_q  <= (wr_data && full) || (ov_q && !rd_stat);
      rd_q  <= rd_stat ? {24'h0, occ, ov_q, empty, full, busy} : 32'h0;
      irq_q <= empty && state_q == IDLE;
      // tx follows the current state one cycle late, so every bit keeps its full width
      tx_q  <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE:  if (pop) state_q <= START;
        START: if (bit_end) begin
          state_q <= DATA;
          bit_q   <= '0;
        end
        DATA:  if (bit_end) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 1'b1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        default: if (bit_end) state_q <= pop ? START : IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench; bus driver queues expectations, read and serial-line monitors check them
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  typedef struct {logic [31:0] val; int id;} rd_t;
  logic        clk = 1'b0, reset = 1'b1, write_mem = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        tx, irq_empty;
  int          errors = 0, checks = 0, cyc = 0;
  rd_t         rdq[$];
  rd_t         re;
  logic [7:0]  txq[$];
  int          starts[$];
  logic        issue = 1'b0, pend = 1'b0;

  uart_tx_mmio #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .write_mem(write_mem), .funct3(funct3), .address(address),
    .write_data(write_data), .read_data(read_data), .tx(tx), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    pend <= issue;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (pend) begin
    if (rdq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rd_unexpected: got %h expected no load", read_data);
    end else begin
      re = rdq.pop_front();
      check($sformatf("rd%0d", re.id), read_data, re.val);
    end
  end

  // serial monitor: samples every cycle of a frame, abandons it if reset is seen
  initial begin : rx
    logic [7:0] e;
    logic [9:0] bits;
    logic       stable, aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        starts.push_back(cyc);
        bits = '0;
        stable = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 100; k++) begin
          if (k > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (k % 10 == 0) bits[k/10] = tx;
          else if (tx !== bits[k/10]) stable = 1'b0;
        end
        if (!aborted) begin
          if (txq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got byte %h expected no frame", bits[8:1]);
          end else begin
            e = txq.pop_front();
            check("rx_byte", {24'h0, bits[8:1]}, {24'h0, e});
            check("rx_frame", {29'h0, stable, bits[9], bits[0]}, 32'h6);
          end
        end
      end
    end
  end

  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input int id);
    @(posedge clk) #1;
    write_mem  = wr;
    address    = a;
    write_data = d;
    issue      = chk;
    if (chk) rdq.push_back('{exp, id});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk) #1;
      write_mem = 1'b0;
      address   = '0;
      issue     = 1'b0;
    end
  endtask

  task automatic store(input logic [31:0] d, input logic acc);
    bus(1'b1, BASE, d, 1'b0, '0, 0);
    if (acc) txq.push_back(d[7:0]);
  endtask

  task automatic rd_status(input logic [31:0] exp, input int id);
    bus(1'b0, BASE + 32'd4, '0, 1'b1, exp, id);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((txq.size() != 0 || irq_empty !== 1'b1) && n < 2000) begin
      @(posedge clk) #1;
      n++;
    end
    check(name, {31'h0, irq_empty}, 32'h1);
    check({name, "_q"}, txq.size(), 0);
  endtask

  initial begin
    int n;
    logic hi;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq_empty}, 32'h1);
    check("rst_rd", read_data, 32'h0);
    hi = 1'b1;
    repeat (50) begin
      @(posedge clk) #1;
      if (tx !== 1'b1) hi = 1'b0;
    end
    check("idle_tx", {31'h0, hi}, 32'h1);
    rd_status(32'h4, 1);
    idle(1);
    check("idle_irq", {31'h0, irq_empty}, 32'h1);
    // single byte: tx falls two edges after the store, irq back once the frame ends
    store(32'h155, 1'b1);
    idle(1);
    @(posedge clk) #1;
    check("lat_n1_tx", {31'h0, tx}, 32'h1);
    check("lat_n1_irq", {31'h0, irq_empty}, 32'h0);
    @(posedge clk) #1;
    check("lat_n2_tx", {31'h0, tx}, 32'h0);
    n = 2;
    while (irq_empty !== 1'b1 && n < 200) begin
      @(posedge clk) #1;
      n++;
    end
    check("irq_ret", n, 102);
    wait_idle("t2_done");
    // five bytes back to back, the first pop frees a slot for the fifth
    n = starts.size();
    for (int i = 1; i <= 5; i++) store(i, 1'b1);
    rd_status(32'h43, 2);
    rd_status(32'h43, 3);
    idle(1);
    wait_idle("t3_done");
    for (int i = n + 1; i < n + 5; i++) check("gap", starts[i] - starts[i-1], 100);
    rd_status(32'h4, 4);
    idle(1);
    // seven bytes: two dropped, overflow sticky until one STATUS read
    for (int i = 0; i < 7; i++) store(32'h10 + i, i < 5);
    rd_status(32'h4B, 5);
    rd_status(32'h43, 6);
    idle(1);
    wait_idle("t4_done");
    // reset mid-frame flushes the fifo and abandons the frame
    store(32'hA5, 1'b1);
    store(32'h3C, 1'b1);
    idle(1);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    check("t5_start", {31'h0, tx}, 32'h0);
    repeat (34) @(posedge clk);
    @(posedge clk) #1;
    reset = 1'b1;
    txq.delete();
    @(posedge clk) #1;
    reset = 1'b0;
    check("t5_tx", {31'h0, tx}, 32'h1);
    rd_status(32'h4, 7);
    idle(300);
    check("t5_irq", {31'h0, irq_empty}, 32'h1);
    // accesses that must neither push nor return data
    bus(1'b1, BASE + 32'd4, 32'h77, 1'b1, 32'h0, 8);
    bus(1'b0, BASE, '0, 1'b1, 32'h0, 9);
    bus(1'b1, BASE + 32'd8, 32'h66, 1'b1, 32'h0, 10);
    bus(1'b0, BASE + 32'd12, '0, 1'b1, 32'h0, 11);
    rd_status(32'h4, 12);
    idle(300);
    check("t6_irq", {31'h0, irq_empty}, 32'h1);
    check("sb_rd_left", rdq.size(), 0);
    check("sb_tx_left", txq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
